// File: rtl/store_sequencer.sv
// store_sequencer: sequences one CPU store onto the data-memory bus.
// Decodes the store size, rotates the write data onto byte lanes and builds
// the byte enables. A store that crosses a word boundary is split into two
// word-aligned bus transactions. Exactly one completion is reported per store.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_st_valid/o_st_ready   store request handshake (ready only in IDLE)
//   i_st_sb, i_st_sh    size select: 00=sw, 01=sh, 10=sb, 11=sw
//   i_st_addr           byte address of the store
//   i_st_wdata          store data in the low bits
//   o_st_done, o_st_err one-cycle completion pulse and its error flag
//   o_busy              high whenever not IDLE
//   o_mem_req/i_mem_gnt bus request, held until granted
//   o_mem_addr/we/be/wdata  word-aligned request fields
//   i_mem_rvalid, i_mem_err bus response and error
module store_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_st_valid,
    output logic              o_st_ready,
    input  logic              i_st_sb,
    input  logic              i_st_sh,
    input  logic [ADDR_W-1:0] i_st_addr,
    input  logic [31:0]       i_st_wdata,
    output logic              o_st_done,
    output logic              o_st_err,
    output logic              o_busy,
    output logic              o_mem_req,
    input  logic              i_mem_gnt,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [3:0]        o_mem_be,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_rvalid,
    input  logic              i_mem_err
);
    typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2} state_t;

    state_t            r_state;
    logic [3:0]        r_be_hi;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;
    logic              r_st_done;
    logic              r_st_err;

    logic [1:0]  w_off;
    logic [3:0]  w_mask;
    logic [7:0]  w_be8;
    logic [63:0] w_dbl;

    assign w_off  = i_st_addr[1:0];
    assign w_mask = (i_st_sb && !i_st_sh) ? 4'b0001 : (i_st_sh && !i_st_sb) ? 4'b0011 : 4'b1111;
    assign w_be8  = {4'b0000, w_mask} << w_off;
    // Upper word of {d,d} shifted left is d rotated left by the same amount.
    assign w_dbl  = {i_st_wdata, i_st_wdata} << {w_off, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_be_hi     <= 4'b0000;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'h0;
            r_st_done   <= 1'b0;
            r_st_err    <= 1'b0;
        end else begin
            r_st_done <= 1'b0;
            r_st_err  <= 1'b0;
            case (r_state)
                IDLE: if (i_st_valid) begin
                    r_state     <= REQ1;
                    r_be_hi     <= w_be8[7:4];
                    r_mem_req   <= 1'b1;
                    r_mem_addr  <= {i_st_addr[ADDR_W-1:2], 2'b00};
                    r_mem_be    <= w_be8[3:0];
                    r_mem_wdata <= w_dbl[63:32];
                end
                REQ1, REQ2: if (i_mem_gnt) begin
                    r_mem_req <= 1'b0;
                    r_state   <= (r_state == REQ1) ? WAIT1 : WAIT2;
                end
                WAIT1: if (i_mem_rvalid) begin
                    // A first-half error ends the store without the second half.
                    if (i_mem_err || r_be_hi == 4'b0000) begin
                        r_state   <= IDLE;
                        r_st_done <= 1'b1;
                        r_st_err  <= i_mem_err;
                    end else begin
                        r_state    <= REQ2;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_mem_addr + ADDR_W'(4);
                        r_mem_be   <= r_be_hi;
                    end
                end
                WAIT2: if (i_mem_rvalid) begin
                    r_state   <= IDLE;
                    r_st_done <= 1'b1;
                    r_st_err  <= i_mem_err;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_st_ready  = (r_state == IDLE);
    assign o_busy      = (r_state != IDLE);
    assign o_st_done   = r_st_done;
    assign o_st_err    = r_st_err;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_req;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_be    = r_mem_be;
    assign o_mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_store_sequencer.sv
// tb_store_sequencer: directed vector bench for store_sequencer.
module tb_store_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0, st_sb = 1'b0, st_sh = 1'b0;
    logic [31:0] st_addr = 32'h0, st_wdata = 32'h0;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
    logic        st_ready, st_done, st_err, busy, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int n_pass = 0;
    int n_tot  = 0;

    store_sequencer #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_st_valid(st_valid), .o_st_ready(st_ready),
        .i_st_sb(st_sb), .i_st_sh(st_sh),
        .i_st_addr(st_addr), .i_st_wdata(st_wdata),
        .o_st_done(st_done), .o_st_err(st_err), .o_busy(busy),
        .o_mem_req(mem_req), .i_mem_gnt(mem_gnt),
        .o_mem_addr(mem_addr), .o_mem_we(mem_we),
        .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
        .i_mem_rvalid(mem_rvalid), .i_mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sb, sh;
        logic [31:0] addr, wdata;
        logic        split;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] a2;
        logic [3:0]  be2;
        logic [31:0] wd;
        logic        e1, e2, xerr;
    } vec_t;

    vec_t v[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic half(input vec_t t, input logic [31:0] a, input logic [3:0] be, input logic e);
        chk("req", mem_req, 1);
        chk("we", mem_we, 1);
        chk("addr", mem_addr, a);
        chk("be", mem_be, be);
        chk("wdata", mem_wdata, t.wd);
        chk("busy", busy, 1);
        repeat (2) @(negedge clk);
        chk("req_hold", {mem_req, mem_addr, mem_be}, {1'b1, a, be});
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("req_drop", {mem_req, mem_we}, 2'b00);
        mem_rvalid = 1'b1;
        mem_err = e;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_err = 1'b0;
    endtask

    task automatic run(input vec_t t);
        @(negedge clk);
        chk("ready", st_ready, 1);
        st_valid = 1'b1;
        st_sb = t.sb;
        st_sh = t.sh;
        st_addr = t.addr;
        st_wdata = t.wdata;
        @(negedge clk);
        st_valid = 1'b0;
        half(t, t.a1, t.be1, t.e1);
        if (t.split && !t.e1) begin
            chk("st_done_mid", st_done, 0);
            half(t, t.a2, t.be2, t.e2);
        end else begin
            chk("no_req2", mem_req, 0);
        end
        chk("st_done", st_done, 1);
        chk("st_err", st_err, t.xerr);
        chk("ready_done", st_ready, 1);
        @(negedge clk);
        chk("done_pulse", st_done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        //        sb    sh    addr          wdata         sp    a1            be1      a2            be2      wd            e1    e2    xerr
        v[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'hDEADBEEF, 1'b0, 32'h0000_0100, 4'b1111, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
        v[1] = '{1'b1, 1'b0, 32'h0000_0203, 32'h0000_00A5, 1'b0, 32'h0000_0200, 4'b1000, 32'h0, 4'b0000, 32'hA500_0000, 1'b0, 1'b0, 1'b0};
        v[2] = '{1'b0, 1'b0, 32'h0000_0102, 32'h1122_3344, 1'b1, 32'h0000_0100, 4'b1100, 32'h0000_0104, 4'b0011, 32'h3344_1122, 1'b0, 1'b0, 1'b0};
        v[3] = '{1'b0, 1'b1, 32'h0000_0007, 32'h0000_BEEF, 1'b1, 32'h0000_0004, 4'b1000, 32'h0000_0008, 4'b0001, 32'hEF00_00BE, 1'b0, 1'b0, 1'b0};
        v[4] = '{1'b0, 1'b0, 32'h0000_00FE, 32'hCAFE_F00D, 1'b1, 32'h0000_00FC, 4'b1100, 32'h0000_0100, 4'b0011, 32'hF00D_CAFE, 1'b1, 1'b0, 1'b1};
        v[5] = '{1'b0, 1'b0, 32'hFFFF_FFFE, 32'h1234_5678, 1'b1, 32'hFFFF_FFFC, 4'b1100, 32'h0000_0000, 4'b0011, 32'h5678_1234, 1'b0, 1'b0, 1'b0};
        v[6] = '{1'b0, 1'b1, 32'h0000_0002, 32'h0000_ABCD, 1'b0, 32'h0000_0000, 4'b1100, 32'h0, 4'b0000, 32'hABCD_0000, 1'b0, 1'b0, 1'b0};
        v[7] = '{1'b0, 1'b1, 32'h0000_0003, 32'h0000_1234, 1'b1, 32'h0000_0000, 4'b1000, 32'h0000_0004, 4'b0001, 32'h3400_0012, 1'b0, 1'b1, 1'b1};
        v[8] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0102_0304, 1'b0, 32'h0000_0010, 4'b1111, 32'h0, 4'b0000, 32'h0102_0304, 1'b0, 1'b0, 1'b0};
        v[9] = '{1'b1, 1'b0, 32'h0000_0001, 32'hFFFF_FF5A, 1'b0, 32'h0000_0000, 4'b0010, 32'h0, 4'b0000, 32'hFFFF_5AFF, 1'b0, 1'b0, 1'b0};

        #12;
        chk("rst_outs", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, 70'h0);
        chk("rst_status", {st_ready, st_done, st_err, busy}, 4'b1000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run(v[i]);

        // rvalid before grant and a new st_valid while busy are both ignored
        @(negedge clk);
        st_valid = 1'b1; st_sb = 1'b0; st_sh = 1'b0; st_addr = 32'h40; st_wdata = 32'h55;
        @(negedge clk);
        st_addr = 32'h80;
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rv_in_req1", {mem_req, st_done, mem_addr}, {1'b1, 1'b0, 32'h40});
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        st_valid = 1'b0;
        chk("busy_done", {st_done, st_err, mem_req}, 3'b100);
        @(negedge clk);
        chk("no_replay", {mem_req, busy}, 2'b00);

        // reset while REQ1 drops the store
        st_valid = 1'b1; st_addr = 32'h100; st_wdata = 32'h77;
        @(negedge clk);
        st_valid = 1'b0;
        chk("pre_rst_req", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_drop", {mem_req, mem_we, mem_be, busy, st_ready}, 8'b0000_0001);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            seen |= st_done | mem_req;
        end
        chk("rst_no_done", {seen, st_ready}, 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
